// File: rtl/aib_rx_pattern_chk.sv
// aib_rx_pattern_chk: AIB RX FIFO incrementing-pattern checker.
// Locks onto a continuous 32-bit incrementing sequence carried over ten
// 32-bit lanes. Once locked it counts checked words and mismatching words.
// Lock is lost after a run of bad words, on link loss, or when the
// checker is disabled.
module aib_rx_pattern_chk #(
    parameter int SYNC_CNT = 4,
    parameter int LOSS_CNT = 8
) (
    input  logic         m_rd_clk,
    input  logic         adapt_rst,
    input  logic         chk_en,
    input  logic         rx_transfer_en,
    input  logic         rx_align_done,
    input  logic         data_vld,
    input  logic [319:0] data_in_f,
    input  logic         err_clr,
    output logic [2:0]   chk_state,
    output logic         chk_locked,
    output logic         err_flag,
    output logic [15:0]  err_cnt,
    output logic [31:0]  word_cnt
);

    localparam logic [3:0] SYNC_N = 4'(SYNC_CNT);
    localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        SYNC  = 3'd2,
        CHECK = 3'd3
    } state_t;

    state_t      state;
    logic [3:0]  good_cnt;
    logic [3:0]  bad_cnt;
    logic [31:0] exp_val;

    logic [31:0] lane0;
    logic        seq_ok;
    logic        exp_ok;
    logic        good_word;
    logic        link_up;

    assign lane0     = data_in_f[31:0];
    assign link_up   = rx_transfer_en & rx_align_done;
    assign chk_state = state;

    // Lane consistency (lanes relative to lane0) and match against expected
    always_comb begin
        seq_ok = 1'b1;
        exp_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (data_in_f[32*i +: 32] != lane0 + 32'(i))
                seq_ok = 1'b0;
            if (data_in_f[32*i +: 32] != exp_val + 32'(i))
                exp_ok = 1'b0;
        end
    end

    // The first word of a sync attempt only needs internal consistency;
    // later words must also continue from the previous one.
    assign good_word = data_vld & seq_ok & ((good_cnt == 4'd0) | (lane0 == exp_val));

    // Checker state machine with registered lock and statistics
    always_ff @(posedge m_rd_clk) begin
        if (adapt_rst) begin
            state      <= IDLE;
            chk_locked <= 1'b0;
            err_flag   <= 1'b0;
            err_cnt    <= 16'd0;
            word_cnt   <= 32'd0;
            good_cnt   <= 4'd0;
            bad_cnt    <= 4'd0;
            exp_val    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    chk_locked <= 1'b0;
                    if (chk_en) state <= WAIT;
                end
                WAIT: begin
                    chk_locked <= 1'b0;
                    if (!chk_en)      state <= IDLE;
                    else if (link_up) state <= SYNC;
                end
                SYNC: begin
                    if (!chk_en) begin
                        state    <= IDLE;
                        good_cnt <= 4'd0;
                        bad_cnt  <= 4'd0;
                    end else if (!link_up) begin
                        state    <= WAIT;
                        good_cnt <= 4'd0;
                        bad_cnt  <= 4'd0;
                    end else if (data_vld) begin
                        if (good_word) begin
                            exp_val <= lane0 + 32'd10;
                            if (good_cnt + 4'd1 == SYNC_N) begin
                                state      <= CHECK;
                                chk_locked <= 1'b1;
                                good_cnt   <= 4'd0;
                                bad_cnt    <= 4'd0;
                            end else begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end else begin
                            good_cnt <= 4'd0;
                        end
                    end
                end
                CHECK: begin
                    if (!chk_en) begin
                        state      <= IDLE;
                        chk_locked <= 1'b0;
                        good_cnt   <= 4'd0;
                        bad_cnt    <= 4'd0;
                    end else if (!link_up) begin
                        state      <= WAIT;
                        chk_locked <= 1'b0;
                        good_cnt   <= 4'd0;
                        bad_cnt    <= 4'd0;
                    end else if (data_vld) begin
                        // Expected value tracks the stream even through errors
                        exp_val <= exp_val + 32'd10;
                        if (word_cnt != 32'hFFFF_FFFF) word_cnt <= word_cnt + 32'd1;
                        if (!exp_ok) begin
                            err_flag <= 1'b1;
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                            if (bad_cnt + 4'd1 == LOSS_N) begin
                                state      <= SYNC;
                                chk_locked <= 1'b0;
                                good_cnt   <= 4'd0;
                                bad_cnt    <= 4'd0;
                            end else begin
                                bad_cnt <= bad_cnt + 4'd1;
                            end
                        end else begin
                            bad_cnt <= 4'd0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    chk_locked <= 1'b0;
                end
            endcase
            // Statistics clear overrides any update made this cycle
            if (err_clr) begin
                err_cnt  <= 16'd0;
                err_flag <= 1'b0;
                word_cnt <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_aib_rx_pattern_chk.sv
// Directed testbench for aib_rx_pattern_chk.
module tb_aib_rx_pattern_chk;

    logic         m_rd_clk = 1'b0;
    logic         adapt_rst = 1'b1;
    logic         chk_en = 1'b0;
    logic         rx_transfer_en = 1'b0;
    logic         rx_align_done = 1'b0;
    logic         data_vld = 1'b0;
    logic [319:0] data_in_f = '0;
    logic         err_clr = 1'b0;
    logic [2:0]   chk_state;
    logic         chk_locked;
    logic         err_flag;
    logic [15:0]  err_cnt;
    logic [31:0]  word_cnt;

    int checks = 0;
    int failures = 0;

    logic [319:0] no_flip;
    logic [319:0] flip_l5;
    logic [319:0] flip_l0;

    aib_rx_pattern_chk #(.SYNC_CNT(4), .LOSS_CNT(8)) dut (
        .m_rd_clk(m_rd_clk), .adapt_rst(adapt_rst), .chk_en(chk_en),
        .rx_transfer_en(rx_transfer_en), .rx_align_done(rx_align_done),
        .data_vld(data_vld), .data_in_f(data_in_f), .err_clr(err_clr),
        .chk_state(chk_state), .chk_locked(chk_locked), .err_flag(err_flag),
        .err_cnt(err_cnt), .word_cnt(word_cnt)
    );

    always #5 m_rd_clk = ~m_rd_clk;

    function automatic logic [319:0] mk(input logic [31:0] b);
        logic [319:0] w;
        for (int i = 0; i < 10; i++) w[32*i +: 32] = b + 32'(i);
        return w;
    endfunction

    task automatic tick();
        @(posedge m_rd_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] b, input logic [319:0] flip);
        data_in_f = mk(b) ^ flip;
        data_vld  = 1'b1;
        tick();
        data_vld  = 1'b0;
    endtask

    task automatic lock_seq(input logic [31:0] b);
        for (int k = 0; k < 4; k++) send(b + 32'(10 * k), no_flip);
    endtask

    task automatic test_reset();
        adapt_rst = 1'b1;
        tick(); tick();
        checks++; if (chk_state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", chk_state); end
        checks++; if (chk_locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b exp=0", chk_locked); end
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%b exp=0", err_flag); end
        checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_errcnt got=%0d exp=0", err_cnt); end
        checks++; if (word_cnt !== 32'd0) begin failures++; $display("FAIL reset_wordcnt got=%0d exp=0", word_cnt); end
        adapt_rst = 1'b0;
    endtask

    task automatic test_lock();
        chk_en = 1'b1;
        tick();
        checks++; if (chk_state !== 3'd1) begin failures++; $display("FAIL lock_wait got=%0d exp=1", chk_state); end
        rx_transfer_en = 1'b1; rx_align_done = 1'b1;
        tick();
        checks++; if (chk_state !== 3'd2) begin failures++; $display("FAIL lock_sync got=%0d exp=2", chk_state); end
        send(32'd0, no_flip); send(32'd10, no_flip); send(32'd20, no_flip);
        checks++; if (chk_locked !== 1'b0 || chk_state !== 3'd2) begin failures++; $display("FAIL lock_early got=%b/%0d exp=0/2", chk_locked, chk_state); end
        send(32'd30, no_flip);
        checks++; if (chk_locked !== 1'b1 || chk_state !== 3'd3) begin failures++; $display("FAIL lock_done got=%b/%0d exp=1/3", chk_locked, chk_state); end
        checks++; if (err_cnt !== 16'd0 || word_cnt !== 32'd0) begin failures++; $display("FAIL lock_stats got=%0d/%0d exp=0/0", err_cnt, word_cnt); end
    endtask

    task automatic test_wrap();
        adapt_rst = 1'b1; tick(); adapt_rst = 1'b0;
        tick(); tick();
        lock_seq(32'hFFFF_FFD2);
        checks++; if (chk_state !== 3'd3) begin failures++; $display("FAIL wrap_lock got=%0d exp=3", chk_state); end
        send(32'hFFFF_FFFA, no_flip);
        checks++; if (err_cnt !== 16'd0 || word_cnt !== 32'd1) begin failures++; $display("FAIL wrap_w1 got=%0d/%0d exp=0/1", err_cnt, word_cnt); end
        data_in_f = {10{32'hDEAD_BEEF}}; data_vld = 1'b0;
        tick();
        checks++; if (word_cnt !== 32'd1 || err_cnt !== 16'd0) begin failures++; $display("FAIL novld got=%0d/%0d exp=1/0", word_cnt, err_cnt); end
        send(32'h0000_0004, no_flip);
        checks++; if (err_cnt !== 16'd0 || word_cnt !== 32'd2 || err_flag !== 1'b0) begin failures++; $display("FAIL wrap_w2 got=%0d/%0d/%b exp=0/2/0", err_cnt, word_cnt, err_flag); end
    endtask

    task automatic test_single_error();
        send(32'h0E, flip_l5);
        checks++; if (err_cnt !== 16'd1 || err_flag !== 1'b1) begin failures++; $display("FAIL single_err got=%0d/%b exp=1/1", err_cnt, err_flag); end
        checks++; if (chk_locked !== 1'b1 || word_cnt !== 32'd3) begin failures++; $display("FAIL single_lock got=%b/%0d exp=1/3", chk_locked, word_cnt); end
        send(32'h18, no_flip);
        checks++; if (err_cnt !== 16'd1 || word_cnt !== 32'd4) begin failures++; $display("FAIL single_next got=%0d/%0d exp=1/4", err_cnt, word_cnt); end
    endtask

    task automatic test_loss();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        checks++; if (err_cnt !== 16'd0 || err_flag !== 1'b0 || word_cnt !== 32'd0 || chk_state !== 3'd3 || chk_locked !== 1'b1) begin failures++; $display("FAIL clr got=%0d/%b/%0d/%0d/%b exp=0/0/0/3/1", err_cnt, err_flag, word_cnt, chk_state, chk_locked); end
        for (int k = 0; k < 7; k++) send(32'h22 + 32'(10 * k), flip_l0);
        checks++; if (chk_state !== 3'd3 || err_cnt !== 16'd7) begin failures++; $display("FAIL loss_7 got=%0d/%0d exp=3/7", chk_state, err_cnt); end
        send(32'h22 + 32'd70, flip_l0);
        checks++; if (chk_state !== 3'd2 || chk_locked !== 1'b0 || err_cnt !== 16'd8) begin failures++; $display("FAIL loss_8 got=%0d/%b/%0d exp=2/0/8", chk_state, chk_locked, err_cnt); end
        send(32'd100, no_flip); send(32'd110, no_flip); send(32'd120, no_flip);
        checks++; if (chk_state !== 3'd2) begin failures++; $display("FAIL relock_early got=%0d exp=2", chk_state); end
        send(32'd130, no_flip);
        checks++; if (chk_state !== 3'd3 || chk_locked !== 1'b1 || word_cnt !== 32'd8) begin failures++; $display("FAIL relock got=%0d/%b/%0d exp=3/1/8", chk_state, chk_locked, word_cnt); end
    endtask

    task automatic test_link_drop();
        rx_align_done = 1'b0;
        tick();
        checks++; if (chk_state !== 3'd1 || chk_locked !== 1'b0) begin failures++; $display("FAIL drop got=%0d/%b exp=1/0", chk_state, chk_locked); end
        checks++; if (err_cnt !== 16'd8 || word_cnt !== 32'd8 || err_flag !== 1'b1) begin failures++; $display("FAIL drop_hold got=%0d/%0d/%b exp=8/8/1", err_cnt, word_cnt, err_flag); end
        rx_align_done = 1'b1;
        tick();
        checks++; if (chk_state !== 3'd2) begin failures++; $display("FAIL drop_resync got=%0d exp=2", chk_state); end
        lock_seq(32'd200);
        err_clr = 1'b1;
        send(32'd240, flip_l0);
        err_clr = 1'b0;
        checks++; if (err_cnt !== 16'd0 || word_cnt !== 32'd0 || err_flag !== 1'b0 || chk_state !== 3'd3) begin failures++; $display("FAIL clr_win got=%0d/%0d/%b/%0d exp=0/0/0/3", err_cnt, word_cnt, err_flag, chk_state); end
        send(32'd250, flip_l0);
        checks++; if (err_cnt !== 16'd1 || word_cnt !== 32'd1) begin failures++; $display("FAIL post_clr got=%0d/%0d exp=1/1", err_cnt, word_cnt); end
        chk_en = 1'b0; rx_align_done = 1'b0;
        tick();
        checks++; if (chk_state !== 3'd0 || chk_locked !== 1'b0 || err_cnt !== 16'd1 || word_cnt !== 32'd1) begin failures++; $display("FAIL disable got=%0d/%b/%0d/%0d exp=0/0/1/1", chk_state, chk_locked, err_cnt, word_cnt); end
        rx_align_done = 1'b1;
    endtask

    task automatic test_reset_mid_check();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk_en = 1'b1;
        tick(); tick();
        lock_seq(32'd0);
        send(32'd40, flip_l0); send(32'd50, flip_l0); send(32'd60, flip_l0);
        checks++; if (err_cnt !== 16'd3 || chk_locked !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%b exp=3/1", err_cnt, chk_locked); end
        adapt_rst = 1'b1;
        data_in_f = mk(32'd70) ^ flip_l0; data_vld = 1'b1;
        tick();
        data_vld = 1'b0;
        checks++; if (chk_state !== 3'd0 || chk_locked !== 1'b0 || err_flag !== 1'b0 || err_cnt !== 16'd0 || word_cnt !== 32'd0) begin failures++; $display("FAIL mid_rst got=%0d/%b/%b/%0d/%0d exp=0/0/0/0/0", chk_state, chk_locked, err_flag, err_cnt, word_cnt); end
        adapt_rst = 1'b0;
    endtask

    initial begin
        no_flip = '0;
        flip_l5 = '0; flip_l5[160] = 1'b1;
        flip_l0 = '0; flip_l0[8] = 1'b1;
        test_reset();
        test_lock();
        test_wrap();
        test_single_error();
        test_loss();
        test_link_drop();
        test_reset_mid_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aib_rx_pattern_chk.md
AIB_RX_PATTERN_CHK -- requirements
Module: aib_rx_pattern_chk

Interface
REQ-001 Parameter SYNC_CNT, default 4: consecutive good words required to lock (range 1..15).
REQ-002 Parameter LOSS_CNT, default 8: consecutive bad words that drop lock (range 1..15).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 m_rd_clk  in  1  sole clock; the same MAC-side FIFO read clock that the RX adapter FIFO read data is timed to.
REQ-005 adapt_rst  in  1  synchronous active-high reset.
REQ-006 chk_en  in  1  checker enable (CSR).
REQ-007 rx_transfer_en  in  1  RX transfer enable from the calibration state machine.
REQ-008 rx_align_done  in  1  RX word-align done from the RX adapter channel.
REQ-009 data_vld  in  1  data_in_f holds a new FIFO word this cycle.
REQ-010 data_in_f  in  320  RX FIFO read data, ten 32-bit lanes; lane i = bits [32i+31:32i].
REQ-011 err_clr  in  1  single-cycle clear of the statistics.
REQ-012 chk_state  out  3  current state encoding.
REQ-013 chk_locked  out  1  pattern lock indicator.
REQ-014 err_flag  out  1  sticky error seen.
REQ-015 err_cnt  out  16  count of mismatching words, saturating.
REQ-016 word_cnt  out  32  count of words checked while locked, saturating.

Function
REQ-017 Expected pattern: continuous 32-bit incrementing sequence; word lane i = B+i, next word B+10; all sums mod 2^32.
REQ-018 States and chk_state encodings: IDLE=0, WAIT=1, SYNC=2, CHECK=3; encodings 4..7 are never reached.
REQ-019 IDLE: chk_en=1 -> WAIT next cycle; otherwise stay in IDLE.
REQ-020 WAIT: rx_transfer_en & rx_align_done both 1 -> SYNC next cycle.
REQ-021 SYNC, good word = data_vld=1, lanes 1..9 each equal lane0+i, and (if prior good-word count >0) lane0 equals stored expected; on good word store expected = lane0+10 and increment the good counter.
REQ-022 SYNC, data_vld=1 with a non-good word: good counter resets to 0 and the expected value is not updated; data_vld=0 changes nothing.
REQ-023 SYNC: on the SYNC_CNT-th consecutive good word -> CHECK; chk_locked=1 from the next cycle.
REQ-024 CHECK, data_vld=1: compare all 10 lanes against expected.
REQ-025 CHECK, after each valid word: expected advances by 10 regardless of the compare result, and word_cnt increments (saturating at 0xFFFFFFFF).
REQ-026 CHECK mismatch (any lane): err_cnt +1 (saturating at 0xFFFF), err_flag=1, bad-run counter +1.
REQ-027 CHECK match: bad-run counter cleared.
REQ-028 CHECK: bad-run counter reaching LOSS_CNT -> SYNC next cycle; chk_locked=0 and the good counter is cleared.
REQ-029 err_cnt, err_flag and word_cnt SHALL update on the clock edge that samples the word, so outputs are visible one cycle after the word is presented.
REQ-030 rx_transfer_en=0 or rx_align_done=0 while in SYNC or CHECK -> WAIT next cycle; chk_locked=0; good and bad-run counters cleared.
REQ-031 chk_en=0 in any state -> IDLE next cycle; chk_locked=0; err_cnt, err_flag and word_cnt are held, not cleared.
REQ-032 chk_en=0 takes priority over the link-loss condition of REQ-030.
REQ-033 err_clr=1: err_cnt=0, err_flag=0, word_cnt=0 next cycle; state and lock unaffected.
REQ-034 err_clr coincident with a mismatch: the clear wins and the mismatch is not counted.
REQ-035 Words with data_vld=0 SHALL NOT be checked, counted, or used to advance the expected value.

Reset
REQ-036 adapt_rst=1 on a clock edge: state=IDLE, chk_locked=0, err_flag=0, err_cnt=0, word_cnt=0, internal counters and expected value=0.
REQ-037 adapt_rst SHALL override all other inputs, including a reset asserted mid-CHECK; outputs show reset values on the cycle after the edge.
REQ-038 No output SHALL be X after the first reset edge.

Verification
REQ-039 Lock: chk_en=1, transfer_en=align_done=1, data_vld=1, B=0,10,20,30 -> chk_locked=1 in the cycle after B=30; err_cnt=0.
REQ-040 Wrap: locked; words B=0xFFFFFFFA then 0x00000004 (lanes wrap through 0) -> no error; word_cnt=2.
REQ-041 Single error: locked; one word with lane 5 flipped -> err_cnt=1, err_flag=1, chk_locked stays 1; the next correct word passes.
REQ-042 Loss: locked; 8 consecutive corrupted words -> state=SYNC, chk_locked=0, err_cnt=8; 4 good words restore lock.
REQ-043 Link drop and clear: drop rx_align_done in CHECK -> state=WAIT next cycle, counters held; err_clr together with a mismatch -> err_cnt=0.
REQ-044 Reset mid-CHECK with err_cnt=3 -> all outputs at reset values the next cycle.
